// File: rtl/spi_rx_pkg.sv
// Shared types and widths for the serial byte receive path.
// Pure declarations: no logic, no latency, no flow control.
package spi_rx_pkg;

  localparam int BYTE_W    = 8;
  localparam int BIT_CNT_W = 3;

  typedef enum logic [1:0] {
    IDLE,
    RECV,
    HOLD
  } rx_state_e;

endpackage

// File: rtl/spi_rx_fifo.sv
// DEPTH-entry FIFO with a combinational head. When empty, the head keeps the last popped value (0 after reset).
// Write accepted when not full, or when full with a same-cycle pop (read-first); otherwise wr_rdy is low.
module spi_rx_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 8
) (
  input  logic                   clk,
  input  logic                   rst_b,
  input  logic                   wr_vld,
  output logic                   wr_rdy,
  input  logic [W-1:0]           wr_dat,
  output logic                   rd_vld,
  input  logic                   rd_rdy,
  output logic [W-1:0]           rd_dat,
  output logic [$clog2(DEPTH):0] level
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;
  logic [W-1:0] last_q;
  logic         empty;
  logic         full;
  logic         push;
  logic         pop;

  assign level  = wr_ptr - rd_ptr;
  assign empty  = (level == '0);
  assign full   = (level == (AW+1)'(DEPTH));
  assign pop    = rd_vld && rd_rdy;
  assign wr_rdy = !full || pop;
  assign push   = wr_vld && wr_rdy;
  assign rd_vld = !empty;
  assign rd_dat = empty ? last_q : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      last_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr[AW-1:0]] <= wr_dat;
        wr_ptr              <= wr_ptr + 1'b1;
      end
      if (pop) begin
        last_q <= mem[rd_ptr[AW-1:0]];
        rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

endmodule

// File: rtl/spi_rx_ctrl.sv
// Chip-select framed LSB-first serial-to-byte receiver; a byte is visible one cycle after its 8th bit.
// A byte hitting a full FIFO with no pop is dropped, sets sticky overflow and holds the frame; SPI_RX_TIMEOUT_EN adds partial-byte timeout.
module spi_rx_ctrl
  import spi_rx_pkg::*;
#(
  parameter int DEPTH       = 4,
  parameter int FRAME_BYTES = 0,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic                   clk,
  input  logic                   rst_b,
  input  logic                   ser_bit,
  input  logic                   bit_en,
  input  logic                   cs_b,
  input  logic                   clr_ovf,
  output logic [BYTE_W-1:0]      byte_out,
  output logic                   byte_valid,
  input  logic                   byte_ready,
  output logic [$clog2(DEPTH):0] fifo_level,
  output logic                   frame_done,
  output logic                   overflow,
  output logic                   timeout
);

  localparam int BC_W    = (FRAME_BYTES > 0) ? $clog2(FRAME_BYTES + 1) : 1;
  localparam int FB_LAST = (FRAME_BYTES > 0) ? FRAME_BYTES - 1 : 0;
  localparam bit FB_EN   = (FRAME_BYTES > 0);

  rx_state_e            state_q, state_d;
  logic [BIT_CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [BYTE_W-1:0]    shift_q, shift_d;
  logic [BYTE_W-1:0]    push_dat;
  logic [BC_W-1:0]      byte_cnt_q, byte_cnt_d;
  logic                 push_vld;
  logic                 push_rdy;
  logic                 ovf_evt;
  logic                 frame_done_d;
  logic                 to_hit;

  assign ovf_evt = push_vld && !push_rdy;

`ifdef SPI_RX_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
  logic [TO_W-1:0] to_cnt_q;
  logic            to_run;

  assign to_run = (state_q == RECV) && !cs_b && !bit_en && (bit_cnt_q != '0);
  assign to_hit = to_run && (to_cnt_q == TO_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      to_cnt_q <= '0;
    end else if (!to_run || to_hit) begin
      to_cnt_q <= '0;
    end else begin
      to_cnt_q <= to_cnt_q + 1'b1;
    end
  end
`else
  assign to_hit = 1'b0;
`endif

  always_comb begin
    state_d             = state_q;
    bit_cnt_d           = bit_cnt_q;
    shift_d             = shift_q;
    byte_cnt_d          = byte_cnt_q;
    push_vld            = 1'b0;
    frame_done_d        = 1'b0;
    push_dat            = shift_q;
    push_dat[bit_cnt_q] = ser_bit;
    unique case (state_q)
      IDLE: begin
        if (!cs_b) begin
          state_d = RECV;
          if (bit_en) begin
            shift_d   = push_dat;
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
      end
      RECV: begin
        if (cs_b) begin
          state_d    = IDLE;
          bit_cnt_d  = '0;
          shift_d    = '0;
          byte_cnt_d = '0;
        end else if (bit_en) begin
          shift_d   = push_dat;
          bit_cnt_d = bit_cnt_q + 1'b1;
          // 8th bit: counter wraps to 0 on its own, the byte goes out now
          if (bit_cnt_q == '1) begin
            push_vld   = 1'b1;
            shift_d    = '0;
            byte_cnt_d = byte_cnt_q + 1'b1;
            if (!push_rdy) begin
              state_d = HOLD;
            end else if (FB_EN && (byte_cnt_q == BC_W'(FB_LAST))) begin
              state_d      = HOLD;
              frame_done_d = 1'b1;
            end
          end
        end else if (to_hit) begin
          bit_cnt_d = '0;
          shift_d   = '0;
        end
      end
      HOLD: begin
        if (cs_b) begin
          state_d    = IDLE;
          bit_cnt_d  = '0;
          shift_d    = '0;
          byte_cnt_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q    <= IDLE;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      byte_cnt_q <= '0;
      frame_done <= 1'b0;
      overflow   <= 1'b0;
      timeout    <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      byte_cnt_q <= byte_cnt_d;
      frame_done <= frame_done_d;
      timeout    <= to_hit;
      if (ovf_evt) begin
        overflow <= 1'b1;
      end else if (clr_ovf) begin
        overflow <= 1'b0;
      end
    end
  end

  spi_rx_fifo #(
    .DEPTH (DEPTH),
    .W     (BYTE_W)
  ) u_fifo (
    .clk    (clk),
    .rst_b  (rst_b),
    .wr_vld (push_vld),
    .wr_rdy (push_rdy),
    .wr_dat (push_dat),
    .rd_vld (byte_valid),
    .rd_rdy (byte_ready),
    .rd_dat (byte_out),
    .level  (fifo_level)
  );

endmodule

// File: doc/spi_rx_ctrl.md
Name: spi_rx_ctrl

Overview:
Frame-level receive controller for the serial byte path. It samples LSB-first serial bits inside a chip-select framed transfer and assembles them into bytes. Completed bytes are buffered in a small FIFO and handed downstream over a valid/ready handshake. Partial bytes, frame length, overflow and (optionally) stalled transfers are all handled here, so the consumer only ever sees whole bytes.

Parameters:
DEPTH, 4, FIFO entries; power of 2, ≥2
FRAME_BYTES, 0, bytes per frame before auto-stop; 0 = unlimited
TIMEOUT_CYC, 16, idle cycles before a partial byte is discarded (used only with SPI_RX_TIMEOUT_EN)

Ports:
clk  in  1  clock, all logic on rising edge
rst_b  in  1  asynchronous reset, active low
ser_bit  in  1  serial data bit
bit_en  in  1  ser_bit valid this cycle
cs_b  in  1  frame select, active low
clr_ovf  in  1  clears the sticky overflow flag
byte_out  out  8  FIFO head byte
byte_valid  out  1  FIFO non-empty
byte_ready  in  1  consumer accepts byte_out
fifo_level  out  $clog2(DEPTH)+1  FIFO occupancy
frame_done  out  1  one-cycle pulse when byte FRAME_BYTES of the frame is pushed
overflow  out  1  sticky flag: a byte was dropped
timeout  out  1  one-cycle pulse when a partial byte is discarded by timeout

Behaviour:
- Reset (async assert, sync release) values:
  - all outputs 0, byte_out = 8'h00
  - state = IDLE; bit counter, byte counter and shift register cleared
  - FIFO emptied
- FSM states: IDLE, RECV, HOLD.
- IDLE -> RECV when cs_b=0. The same edge samples a bit if bit_en=1.
- Sampling: in RECV with bit_en=1, ser_bit is written to shift bit [bit_cnt] and bit_cnt increments. The first bit of a byte is bit 0.
- On the 8th bit edge:
  - the assembled byte (including the current ser_bit) is pushed to the FIFO
  - bit_cnt wraps to 0 and the byte counter increments
  - byte_valid/fifo_level reflect the push on the following cycle (1-cycle latency)
- RECV -> IDLE when cs_b=1. Any partial bits are discarded and no push occurs; cs_b=1 takes priority over bit_en in that cycle.
- RECV -> HOLD on either condition:
  - byte counter reaches FRAME_BYTES (FRAME_BYTES≠0); frame_done pulses on the push edge
  - overflow event
- HOLD: bits ignored. HOLD -> IDLE when cs_b=1.
- FIFO rules:
  - pop when byte_valid && byte_ready
  - push to a full FIFO succeeds only if a pop occurs the same cycle; otherwise the byte is dropped, overflow is set, and the FSM goes to HOLD
  - pop from an empty FIFO has no effect
  - byte_out is undefined-free: it holds the last head value (8'h00 after reset)
- overflow clears on clr_ovf=1, unless an overflow event occurs in the same cycle (set wins).
- Byte counter resets on entry to IDLE.
- cs_b toggling has no effect on FIFO contents; only reset empties it.

Optional Feature:
SPI_RX_TIMEOUT_EN
- Defined:
  - in RECV with bit_cnt≠0, a counter increments each cycle with bit_en=0 and clears on bit_en=1
  - at TIMEOUT_CYC: bit_cnt and shift register clear, timeout pulses one cycle, state stays RECV
- Undefined: no counter is built and timeout is tied 0.

Decomposition:
- Package spi_rx_pkg holds:
  - state enum (IDLE, RECV, HOLD)
  - BYTE_W=8
  - BIT_CNT_W=3
- Sub-module spi_rx_fifo (DEPTH parameter) provides push/pop/full/empty/level, read-first on simultaneous push+pop when full.
- Assembly logic and FSM stay in spi_rx_ctrl.

Test Plan:
1. Reset, cs_b=0, bit_en=1, bits 1,1,0,0,1,0,1,0, byte_ready=1 -> byte_out=8'h53, byte_valid=1 for one cycle, fifo_level returns to 0.
2. DEPTH=4, byte_ready=0, 5 bytes of 8'hFF -> fifo_level=4, overflow=1, state HOLD, further bits ignored. Then byte_ready=1 -> four 8'hFF pops. Then clr_ovf -> overflow=0.
3. cs_b=0, 5 bits of 1, cs_b=1, then a new frame with bits 0,1,0,1,0,1,0,1 -> only 8'hAA is pushed; no partial byte appears.
4. FRAME_BYTES=2, 24 bits sent -> bytes 1 and 2 pushed, frame_done pulses on the 16th-bit edge, bits 17–24 dropped. cs_b=1 then 0 -> reception resumes.
5. With SPI_RX_TIMEOUT_EN, TIMEOUT_CYC=16: 3 bits, 16 cycles bit_en=0 -> timeout pulse. Then bits 1,0,1,0,0,1,0,1 -> 8'hA5.
6. rst_b low mid-byte with 2 bytes in the FIFO -> outputs 0 and the FIFO empties immediately. After release, a full byte 8'h53 is received correctly.
